reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_if.sv | 44 ++++
 rtl/reservation_station.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reservation_station_if.sv
// Dispatch, CDB, flush and issue signals between the scheduler and a reservation station.
// master drives dispatch/CDB/flush/issue_ready; slave presents issue/occupancy.
interface reservation_station_if #(
    parameter int RS_SIZE_W = 2
);
    logic                 dispatch_valid;
    logic [3:0]           dispatch_op;
    logic [3:0]           dispatch_tag;
    logic [31:0]          dispatch_vj;
    logic [31:0]          dispatch_vk;
    logic [3:0]           dispatch_qj;
    logic [3:0]           dispatch_qk;
    logic                 dispatch_qj_valid;
    logic                 dispatch_qk_valid;

    logic [3:0]           cdb_tag;
    logic [31:0]          cdb_val;
    logic                 cdb_active;
    logic                 predict_fail;

    logic                 issue_valid;
    logic [3:0]           issue_op;
    logic [3:0]           issue_tag;
    logic [31:0]          issue_vj;
    logic [31:0]          issue_vk;
    logic                 issue_ready;

    logic                 rs_full;
    logic [RS_SIZE_W:0]   rs_count;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_tag, dispatch_vj, dispatch_vk,
               dispatch_qj, dispatch_qk, dispatch_qj_valid, dispatch_qk_valid,
               cdb_tag, cdb_val, cdb_active, predict_fail, issue_ready,
        input  issue_valid, issue_op, issue_tag, issue_vj, issue_vk, rs_full, rs_count
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_tag, dispatch_vj, dispatch_vk,
               dispatch_qj, dispatch_qk, dispatch_qj_valid, dispatch_qk_valid,
               cdb_tag, cdb_val, cdb_active, predict_fail, issue_ready,
        output issue_valid, issue_op, issue_tag, issue_vj, issue_vk, rs_full, rs_count
    );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive via CDB, issues lowest ready entry.
// Ready entries issue the cycle after the writing edge; full drops dispatch, issue held until issue_ready.
module reservation_station #(
    parameter int RS_SIZE   = 4,
    parameter int RS_SIZE_W = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    reservation_station_if.slave   rs_if
);

    typedef struct packed {
        logic        busy;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic        qj_wait;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic        qk_wait;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];

    logic [RS_SIZE_W:0]   count;
    logic [RS_SIZE_W-1:0] free_idx;
    logic [RS_SIZE_W-1:0] sel_idx;
    logic                 free_found;
    logic                 sel_found;
    logic                 full;
    logic                 issue_go;
    logic                 fwd_j;
    logic                 fwd_k;
    entry_t               new_ent;

    // Occupancy, first free slot and first ready slot, all from registered state only.
    always_comb begin
        count      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
                count = count + (RS_SIZE_W+1)'(1);
            end
            if (!ent_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_SIZE_W'(i);
            end
            if (ent_q[i].busy && !ent_q[i].qj_wait && !ent_q[i].qk_wait && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = RS_SIZE_W'(i);
            end
        end
    end

    assign full     = (count == (RS_SIZE_W+1)'(RS_SIZE));
    assign issue_go = sel_found && rdy_in;

    assign rs_if.rs_count    = count;
    assign rs_if.rs_full     = full;
    assign rs_if.issue_valid = issue_go;
    assign rs_if.issue_op    = issue_go ? ent_q[sel_idx].op  : '0;
    assign rs_if.issue_tag   = issue_go ? ent_q[sel_idx].tag : '0;
    assign rs_if.issue_vj    = issue_go ? ent_q[sel_idx].vj  : '0;
    assign rs_if.issue_vk    = issue_go ? ent_q[sel_idx].vk  : '0;

    // An operand whose producer broadcasts in the dispatch cycle is captured as ready.
    always_comb begin
        fwd_j = rs_if.dispatch_qj_valid && rs_if.cdb_active && (rs_if.dispatch_qj == rs_if.cdb_tag);
        fwd_k = rs_if.dispatch_qk_valid && rs_if.cdb_active && (rs_if.dispatch_qk == rs_if.cdb_tag);
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = rs_if.dispatch_op;
        new_ent.tag     = rs_if.dispatch_tag;
        new_ent.qj      = rs_if.dispatch_qj;
        new_ent.qk      = rs_if.dispatch_qk;
        new_ent.qj_wait = rs_if.dispatch_qj_valid && !fwd_j;
        new_ent.qk_wait = rs_if.dispatch_qk_valid && !fwd_k;
        new_ent.vj      = fwd_j ? rs_if.cdb_val : rs_if.dispatch_vj;
        new_ent.vk      = fwd_k ? rs_if.cdb_val : rs_if.dispatch_vk;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (rdy_in) begin
            if (rs_if.predict_fail) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].busy && rs_if.cdb_active) begin
                        if (ent_q[i].qj_wait && ent_q[i].qj == rs_if.cdb_tag) begin
                            ent_d[i].qj_wait = 1'b0;
                            ent_d[i].vj      = rs_if.cdb_val;
                        end
                        if (ent_q[i].qk_wait && ent_q[i].qk == rs_if.cdb_tag) begin
                            ent_d[i].qk_wait = 1'b0;
                            ent_d[i].vk      = rs_if.cdb_val;
                        end
                    end
                end
                if (issue_go && rs_if.issue_ready) begin
                    ent_d[sel_idx].busy = 1'b0;
                end
                // Issue frees a busy slot, dispatch fills a free one: never the same index.
                if (rs_if.dispatch_valid && !full && free_found) begin
                    ent_d[free_idx] = new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
